// File: rtl/bus_arb_pkg.sv
// bus_arb_pkg: constants, FSM state encoding and lane-select helpers shared
// by the two-master bus arbiter (bus_arb2) and its round-robin picker (rr_pick2).
package bus_arb_pkg;

  localparam int unsigned NUM_MASTERS = 2;
  localparam int unsigned ADDR_W      = 32;
  localparam int unsigned DATA_W      = 32;
  localparam int unsigned STRB_W      = DATA_W / 8;
  localparam int unsigned CNT_W       = 16;

  localparam logic [DATA_W-1:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StBusy = 1'b1
  } arb_state_e;

  // Select one 32-bit lane of a packed two-master bus by a one-hot select.
  // A zero select yields zero, which is what the idle downstream port needs.
  function automatic logic [31:0] lane32(input logic [63:0] bus, input logic [1:0] sel);
    return ({32{sel[0]}} & bus[31:0]) | ({32{sel[1]}} & bus[63:32]);
  endfunction

  function automatic logic [3:0] lane4(input logic [7:0] bus, input logic [1:0] sel);
    return ({4{sel[0]}} & bus[3:0]) | ({4{sel[1]}} & bus[7:4]);
  endfunction

endpackage

// File: rtl/rr_pick2.sv
// rr_pick2: two-way round-robin winner selection.
//   req  [1:0] in  : request per master
//   last [1:0] in  : one-hot master granted most recently
//   win  [1:0] out : one-hot winner, 0 when nothing requests
// On a tie the master that was not granted most recently wins.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic [1:0] last,
  output logic [1:0] win
);

  always_comb begin
    win = 2'b00;
    unique case (req)
      2'b01:   win = 2'b01;
      2'b10:   win = 2'b10;
      2'b11:   win = (last == 2'b01) ? 2'b10 : 2'b01;
      default: win = 2'b00;
    endcase
  end

endmodule

// File: rtl/bus_arb2.sv
// bus_arb2: two-master to one-slave arbiter with picorv32-native handshakes.
//
// Ports:
//   clk, reset_l_in          : clock, asynchronous active-low reset
//   m_valid/m_addr/m_wdata/m_wstrb : packed master requests (master i in lane i)
//   m_rdata, m_ready         : shared read data, per-master completion strobe
//   s_valid/s_addr/s_wdata/s_wstrb : downstream request
//   s_rdata, s_ready         : downstream response
//   grant                    : one-hot owner of the downstream port, 0 when idle
//   timeout_err              : sticky forced-completion flag
//
// Optional feature: define BUS_ARB_TIMEOUT_EN to enable the transaction
// watchdog (TIMEOUT cycles, then completion with ERR_DATA). Without it BUSY
// waits indefinitely and timeout_err is tied low.
module bus_arb2
  import bus_arb_pkg::*;
#(
  parameter int unsigned       TIMEOUT  = 255,
  parameter logic [DATA_W-1:0] ERR_DATA = ERR_DATA_DEFAULT
) (
  input  logic                            clk,
  input  logic                            reset_l_in,
  input  logic [NUM_MASTERS-1:0]          m_valid,
  input  logic [NUM_MASTERS*ADDR_W-1:0]   m_addr,
  input  logic [NUM_MASTERS*DATA_W-1:0]   m_wdata,
  input  logic [NUM_MASTERS*STRB_W-1:0]   m_wstrb,
  output logic [DATA_W-1:0]               m_rdata,
  output logic [NUM_MASTERS-1:0]          m_ready,
  output logic                            s_valid,
  output logic [ADDR_W-1:0]               s_addr,
  output logic [DATA_W-1:0]               s_wdata,
  output logic [STRB_W-1:0]               s_wstrb,
  input  logic [DATA_W-1:0]               s_rdata,
  input  logic                            s_ready,
  output logic [NUM_MASTERS-1:0]          grant,
  output logic                            timeout_err
);

  // Reset release is synchronised; arbitration is held off until it lands.
  logic [1:0] r_sync;
  logic       w_run;

  always_ff @(posedge clk or negedge reset_l_in) begin
    if (!reset_l_in) begin
      r_sync <= 2'b00;
    end else begin
      r_sync <= {r_sync[0], 1'b1};
    end
  end

  assign w_run = r_sync[1];

  arb_state_e       r_state;
  arb_state_e       w_state_d;
  logic [1:0]       r_grant;
  logic [1:0]       w_grant_d;
  logic [1:0]       r_last;
  logic [1:0]       w_last_d;
  logic [1:0]       w_win;
  logic             w_busy;
  logic             w_g_valid;
  logic             w_done;
  logic             w_abort;
  logic             w_tout;
  logic             w_release;

  rr_pick2 u_rr_pick2 (
    .req  (m_valid),
    .last (r_last),
    .win  (w_win)
  );

  assign w_busy    = (r_state == StBusy);
  assign w_g_valid = |(m_valid & r_grant);
  // Slave response wins over both abort and timeout in the same cycle.
  assign w_done    = w_busy && s_ready;
  assign w_abort   = w_busy && !s_ready && !w_g_valid;
  assign w_release = w_done || w_abort || w_tout;

`ifdef BUS_ARB_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TimeoutCnt = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_d;
  logic             r_timeout_err;

  assign w_tout = w_busy && w_g_valid && !s_ready && (r_cnt == TimeoutCnt);

  // Held at zero while idle so it starts from zero on entering BUSY.
  always_comb begin
    w_cnt_d = r_cnt;
    if (!w_busy) begin
      w_cnt_d = '0;
    end else if (!s_ready) begin
      w_cnt_d = r_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_l_in) begin
    if (!reset_l_in) begin
      r_cnt         <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_cnt         <= w_cnt_d;
      r_timeout_err <= r_timeout_err | w_tout;
    end
  end

  assign timeout_err = r_timeout_err;
`else
  logic [CNT_W-1:0] w_unused_timeout;

  assign w_unused_timeout = CNT_W'(TIMEOUT);
  assign w_tout           = 1'b0;
  assign timeout_err      = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge reset_l_in) begin
    if (!reset_l_in) begin
      r_state <= StIdle;
      r_grant <= 2'b00;
      r_last  <= 2'b10;
    end else begin
      r_state <= w_state_d;
      r_grant <= w_grant_d;
      r_last  <= w_last_d;
    end
  end

  // Next state. Completion always lands in IDLE, which guarantees the
  // one idle cycle between consecutive grants.
  always_comb begin
    w_state_d = r_state;
    w_grant_d = r_grant;
    w_last_d  = r_last;
    unique case (r_state)
      StIdle: begin
        if (w_run && (|m_valid)) begin
          w_state_d = StBusy;
          w_grant_d = w_win;
          w_last_d  = w_win;
        end
      end
      StBusy: begin
        if (w_release) begin
          w_state_d = StIdle;
          w_grant_d = 2'b00;
        end
      end
      default: begin
        w_state_d = StIdle;
        w_grant_d = 2'b00;
      end
    endcase
  end

  // Outputs. Everything is gated by BUSY so an asynchronous reset
  // silences the downstream port and completion strobes immediately.
  always_comb begin
    s_valid = 1'b0;
    s_addr  = '0;
    s_wdata = '0;
    s_wstrb = '0;
    m_ready = 2'b00;
    m_rdata = '0;
    if (w_busy) begin
      s_valid = w_g_valid && !w_tout;
      s_addr  = lane32(m_addr, r_grant);
      s_wdata = lane32(m_wdata, r_grant);
      s_wstrb = lane4(m_wstrb, r_grant);
      if (w_done) begin
        m_ready = r_grant;
        m_rdata = s_rdata;
      end else if (w_tout) begin
        m_ready = r_grant;
        m_rdata = ERR_DATA;
      end
    end
  end

  assign grant = r_grant;

endmodule

// File: tb/tb_bus_arb2.sv
// Directed self-checking bench for bus_arb2 (TIMEOUT=8).
module tb_bus_arb2;

  logic        clk = 1'b0;
  logic        reset_l_in;
  logic [1:0]  m_valid;
  logic [63:0] m_addr;
  logic [63:0] m_wdata;
  logic [7:0]  m_wstrb;
  logic [31:0] m_rdata;
  logic [1:0]  m_ready;
  logic        s_valid;
  logic [31:0] s_addr;
  logic [31:0] s_wdata;
  logic [3:0]  s_wstrb;
  logic [31:0] s_rdata;
  logic        s_ready;
  logic [1:0]  grant;
  logic        timeout_err;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  bus_arb2 #(
    .TIMEOUT  (8),
    .ERR_DATA (32'hDEAD_BEEF)
  ) dut (
    .clk         (clk),
    .reset_l_in  (reset_l_in),
    .m_valid     (m_valid),
    .m_addr      (m_addr),
    .m_wdata     (m_wdata),
    .m_wstrb     (m_wstrb),
    .m_rdata     (m_rdata),
    .m_ready     (m_ready),
    .s_valid     (s_valid),
    .s_addr      (s_addr),
    .s_wdata     (s_wdata),
    .s_wstrb     (s_wstrb),
    .s_rdata     (s_rdata),
    .s_ready     (s_ready),
    .grant       (grant),
    .timeout_err (timeout_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change at the falling edge; outputs are checked 1 time unit later.
  task automatic nxt();
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0] exp_g;

    reset_l_in = 1'b0;
    m_valid    = 2'b00;
    m_addr     = {32'h0300_0000, 32'h0001_0000};
    m_wdata    = {32'h0000_00AA, 32'h1111_1111};
    m_wstrb    = {4'b0001, 4'b0000};
    s_rdata    = 32'h0;
    s_ready    = 1'b0;

    // Reset state
    nxt(); #1;
    chk("rst_grant", {30'd0, grant}, 32'h0);
    chk("rst_svalid", {31'd0, s_valid}, 32'h0);
    chk("rst_mready", {30'd0, m_ready}, 32'h0);
    chk("rst_mrdata", m_rdata, 32'h0);
    chk("rst_terr", {31'd0, timeout_err}, 32'h0);
    chk("rst_saddr", s_addr, 32'h0);

    // Release reset with m0 already requesting: no grant for two edges
    nxt(); reset_l_in = 1'b1; m_valid = 2'b01; #1;
    chk("sync_g0", {30'd0, grant}, 32'h0);
    nxt(); #1;
    chk("sync_g1", {30'd0, grant}, 32'h0);
    nxt(); #1;
    chk("sync_g2", {30'd0, grant}, 32'h0);
    chk("sync_sv2", {31'd0, s_valid}, 32'h0);

    // m0 read, slave ready two cycles after s_valid
    nxt(); #1;
    chk("rd_grant", {30'd0, grant}, 32'h1);
    chk("rd_svalid", {31'd0, s_valid}, 32'h1);
    chk("rd_saddr", s_addr, 32'h0001_0000);
    chk("rd_swstrb", {28'd0, s_wstrb}, 32'h0);
    chk("rd_mready_b0", {30'd0, m_ready}, 32'h0);
    nxt(); #1;
    chk("rd_mready_b1", {30'd0, m_ready}, 32'h0);
    chk("rd_svalid_b1", {31'd0, s_valid}, 32'h1);
    nxt(); s_ready = 1'b1; s_rdata = 32'h1234_5678; #1;
    chk("rd_mready", {30'd0, m_ready}, 32'h1);
    chk("rd_mrdata", m_rdata, 32'h1234_5678);
    nxt(); s_ready = 1'b0; s_rdata = 32'h0; m_valid = 2'b00; #1;
    chk("rd_idle_grant", {30'd0, grant}, 32'h0);
    chk("rd_idle_mready", {30'd0, m_ready}, 32'h0);
    chk("rd_idle_mrdata", m_rdata, 32'h0);
    chk("rd_idle_saddr", s_addr, 32'h0);

    // Abort: m0 granted, m1 arrives, m0 drops valid in BUSY cycle 2
    nxt(); m_valid = 2'b01; #1;
    chk("ab_idle", {30'd0, grant}, 32'h0);
    nxt(); m_valid = 2'b11; #1;
    chk("ab_grant0", {30'd0, grant}, 32'h1);
    nxt(); m_valid = 2'b10; #1;
    chk("ab_svalid", {31'd0, s_valid}, 32'h0);
    chk("ab_mready", {30'd0, m_ready}, 32'h0);
    nxt(); #1;
    chk("ab_back_idle", {30'd0, grant}, 32'h0);
    chk("ab_idle_mready", {30'd0, m_ready}, 32'h0);

    // m1 write, granted after the abort
    nxt(); #1;
    chk("wr_grant", {30'd0, grant}, 32'h2);
    chk("wr_svalid", {31'd0, s_valid}, 32'h1);
    chk("wr_saddr", s_addr, 32'h0300_0000);
    chk("wr_swdata", s_wdata, 32'h0000_00AA);
    chk("wr_swstrb", {28'd0, s_wstrb}, 32'h1);
    chk("wr_mready_b0", {30'd0, m_ready}, 32'h0);
    nxt(); s_ready = 1'b1; s_rdata = 32'h5555_5555; #1;
    chk("wr_mready", {30'd0, m_ready}, 32'h2);
    chk("wr_mrdata", m_rdata, 32'h5555_5555);
    chk("wr_swdata_b1", s_wdata, 32'h0000_00AA);
    chk("wr_swstrb_b1", {28'd0, s_wstrb}, 32'h1);
    nxt(); m_valid = 2'b00; s_ready = 1'b0; #1;
    chk("wr_idle_mready", {30'd0, m_ready}, 32'h0);
    chk("wr_idle_grant", {30'd0, grant}, 32'h0);

    // Both masters held valid: alternate 0,1,0,1,0,1 with an idle cycle between
    nxt(); m_valid = 2'b11; s_ready = 1'b1; s_rdata = 32'hCAFE_0000;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("rr_idle_grant", {30'd0, grant}, 32'h0);
      chk("rr_idle_mready", {30'd0, m_ready}, 32'h0);
      nxt(); #1;
      exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
      chk("rr_grant", {30'd0, grant}, {30'd0, exp_g});
      chk("rr_mready", {30'd0, m_ready}, {30'd0, exp_g});
      chk("rr_saddr", s_addr, (k % 2 == 0) ? 32'h0001_0000 : 32'h0300_0000);
      nxt();
    end

    // Reset while BUSY
    m_valid = 2'b10; s_ready = 1'b0; #1;
    chk("rb_idle", {30'd0, grant}, 32'h0);
    nxt(); #1;
    chk("rb_grant", {30'd0, grant}, 32'h2);
    chk("rb_svalid", {31'd0, s_valid}, 32'h1);
    #2; reset_l_in = 1'b0; #1;
    chk("rb_svalid_rst", {31'd0, s_valid}, 32'h0);
    chk("rb_grant_rst", {30'd0, grant}, 32'h0);
    chk("rb_mready_rst", {30'd0, m_ready}, 32'h0);
    nxt(); reset_l_in = 1'b1; m_valid = 2'b11; #1;
    chk("rb_rel0", {30'd0, grant}, 32'h0);
    nxt(); #1;
    chk("rb_rel1", {30'd0, grant}, 32'h0);
    nxt(); #1;
    chk("rb_rel2", {30'd0, grant}, 32'h0);
    nxt(); s_ready = 1'b1; s_rdata = 32'h0000_0042; #1;
    chk("rb_first_grant", {30'd0, grant}, 32'h1);
    chk("rb_first_mready", {30'd0, m_ready}, 32'h1);
    nxt(); m_valid = 2'b01; s_ready = 1'b0; #1;
    chk("to_idle", {30'd0, grant}, 32'h0);

`ifdef BUS_ARB_TIMEOUT_EN
    // s_ready on the timeout cycle: normal completion, no error flag
    nxt(); #1;
    chk("tie_grant", {30'd0, grant}, 32'h1);
    for (int i = 1; i < 8; i++) begin
      nxt(); #1;
      chk("tie_wait_mready", {30'd0, m_ready}, 32'h0);
    end
    nxt(); s_ready = 1'b1; s_rdata = 32'h600D_600D; #1;
    chk("tie_mready", {30'd0, m_ready}, 32'h1);
    chk("tie_mrdata", m_rdata, 32'h600D_600D);
    nxt(); s_ready = 1'b0; #1;
    chk("tie_terr", {31'd0, timeout_err}, 32'h0);

    // Slave never ready: forced completion 8 cycles after s_valid
    nxt(); #1;
    chk("to_grant", {30'd0, grant}, 32'h1);
    chk("to_svalid_b0", {31'd0, s_valid}, 32'h1);
    for (int i = 1; i < 8; i++) begin
      nxt(); #1;
      chk("to_wait_mready", {30'd0, m_ready}, 32'h0);
      chk("to_wait_svalid", {31'd0, s_valid}, 32'h1);
    end
    nxt(); #1;
    chk("to_mready", {30'd0, m_ready}, 32'h1);
    chk("to_mrdata", m_rdata, 32'hDEAD_BEEF);
    chk("to_svalid", {31'd0, s_valid}, 32'h0);
    chk("to_terr_pre", {31'd0, timeout_err}, 32'h0);
    nxt(); m_valid = 2'b00; #1;
    chk("to_terr", {31'd0, timeout_err}, 32'h1);
    chk("to_idle_grant", {30'd0, grant}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      nxt(); #1;
      chk("to_terr_sticky", {31'd0, timeout_err}, 32'h1);
    end
    nxt(); reset_l_in = 1'b0; #1;
    chk("to_terr_rst", {31'd0, timeout_err}, 32'h0);
    nxt(); reset_l_in = 1'b1;
`else
    // No watchdog: BUSY waits indefinitely, then the master aborts
    nxt(); #1;
    chk("nto_grant", {30'd0, grant}, 32'h1);
    for (int i = 0; i < 40; i++) begin
      nxt(); #1;
      chk("nto_mready", {30'd0, m_ready}, 32'h0);
      chk("nto_svalid", {31'd0, s_valid}, 32'h1);
      chk("nto_terr", {31'd0, timeout_err}, 32'h0);
    end
    nxt(); m_valid = 2'b00; #1;
    chk("nto_abort_mready", {30'd0, m_ready}, 32'h0);
    chk("nto_abort_svalid", {31'd0, s_valid}, 32'h0);
    nxt(); #1;
    chk("nto_idle", {30'd0, grant}, 32'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
